// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: single owner of the PPU VRAM bus. It arbitrates between
// the CPU PPUDATA port, the palette/colour loader and the tile fetcher.
// Priority depends on render_active. The CPU has a starvation guard
// (MAX_WAIT) and the burst requesters can hold the bus with a lock.
// Optional build macro VRAM_ARB_STATS_EN adds the cpu_stall_cnt output.
module ppu_vram_arbiter #(
   parameter int RD_LAT   = 1,   // read latency, 1..4
   parameter int MAX_WAIT = 16   // CPU losses before a forced grant, 2..255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        render_active,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   input  logic        col_req,
   input  logic        col_lock,
   input  logic [15:0] col_addr,
   output logic        col_ack,
   input  logic        vrl_req,
   input  logic        vrl_lock,
   input  logic [15:0] vrl_addr,
   output logic        vrl_ack,
   output logic [7:0]  rdata,
   output logic [15:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        busy
`ifdef VRAM_ARB_STATS_EN
   ,
   output logic [15:0] cpu_stall_cnt
`endif
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_COL  = 2'd2;
   localparam logic [1:0] OWN_VRL  = 2'd3;

   localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

   logic [1:0]  state;
   logic [1:0]  owner;     // last granted requester; it decides lock continuation
   logic [7:0]  cpu_wait;
   logic [2:0]  cnt;
   logic [1:0]  win;
   logic [15:0] win_addr;

   assign busy = (state != S_IDLE);

   // Winner selection for the IDLE arbitration. The rules are checked from
   // highest to lowest: starvation guard, lock, then render-dependent fixed order.
   always_comb begin
      win = OWN_NONE;
      if (cpu_req && cpu_wait == WAIT_MAX)
         win = OWN_CPU;
      else if (owner == OWN_COL && col_lock && col_req)
         win = OWN_COL;
      else if (owner == OWN_VRL && vrl_lock && vrl_req)
         win = OWN_VRL;
      else if (render_active) begin
         if (vrl_req)      win = OWN_VRL;
         else if (col_req) win = OWN_COL;
         else if (cpu_req) win = OWN_CPU;
      end else begin
         if (cpu_req)      win = OWN_CPU;
         else if (col_req) win = OWN_COL;
         else if (vrl_req) win = OWN_VRL;
      end
   end

   // Address mux for the winning requester.
   always_comb begin
      win_addr = cpu_addr;
      case (win)
         OWN_COL: win_addr = col_addr;
         OWN_VRL: win_addr = vrl_addr;
         default: win_addr = cpu_addr;
      endcase
   end

   // Access sequencer: grant in IDLE, count down the read latency in ACCESS,
   // and hold the one-cycle ack in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         owner     <= OWN_NONE;
         cpu_wait  <= 8'd0;
         cnt       <= 3'd0;
         mem_addr  <= 16'd0;
         mem_wdata <= 8'd0;
         mem_we    <= 1'b0;
         rdata     <= 8'd0;
         cpu_ack   <= 1'b0;
         col_ack   <= 1'b0;
         vrl_ack   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win != OWN_NONE) begin
                  owner     <= win;
                  mem_addr  <= win_addr;
                  mem_wdata <= cpu_wdata;
                  mem_we    <= (win == OWN_CPU) && cpu_we;
                  cnt       <= 3'(RD_LAT);
                  state     <= S_ACCESS;
                  if (win == OWN_CPU)
                     cpu_wait <= 8'd0;
                  else if (cpu_req && cpu_wait != WAIT_MAX)
                     cpu_wait <= cpu_wait + 8'd1;
               end
            end
            S_ACCESS: begin
               // The write strobe only lasts for the first ACCESS cycle.
               mem_we <= 1'b0;
               if (cnt == 3'd0) begin
                  rdata   <= mem_rdata;
                  cpu_ack <= (owner == OWN_CPU);
                  col_ack <= (owner == OWN_COL);
                  vrl_ack <= (owner == OWN_VRL);
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            S_DONE: begin
               cpu_ack <= 1'b0;
               col_ack <= 1'b0;
               vrl_ack <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef VRAM_ARB_STATS_EN
   // Count the cycles in which the CPU is waiting. The counter saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cpu_stall_cnt <= 16'd0;
      else if (cpu_req && !cpu_ack && cpu_stall_cnt != 16'hFFFF)
         cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter (RD_LAT=1, MAX_WAIT=16). Inputs are
// driven and outputs are sampled on the falling edge.
module tb_ppu_vram_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        render_active;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic        col_req, col_lock;
   logic [15:0] col_addr;
   logic        col_ack;
   logic        vrl_req, vrl_lock;
   logic [15:0] vrl_addr;
   logic        vrl_ack;
   logic [7:0]  rdata;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        busy;
`ifdef VRAM_ARB_STATS_EN
   logic [15:0] cpu_stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int ack_log[$];

   always #5 clk = ~clk;

   ppu_vram_arbiter #(.RD_LAT(1), .MAX_WAIT(16)) dut (
      .clk(clk), .rst(rst), .render_active(render_active),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack),
      .col_req(col_req), .col_lock(col_lock), .col_addr(col_addr), .col_ack(col_ack),
      .vrl_req(vrl_req), .vrl_lock(vrl_lock), .vrl_addr(vrl_addr), .vrl_ack(vrl_ack),
      .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
`ifdef VRAM_ARB_STATS_EN
      , .cpu_stall_cnt(cpu_stall_cnt)
`endif
   );

   // Memory model: it returns a fixed value at 2005, remembers the last write,
   // and returns the XOR of the address bytes everywhere else.
   logic        wr_valid = 1'b0;
   logic [15:0] wr_addr  = 16'd0;
   logic [7:0]  wr_data  = 8'd0;
   always @(posedge clk) begin
      if (mem_we) begin
         wr_valid <= 1'b1;
         wr_addr  <= mem_addr;
         wr_data  <= mem_wdata;
      end
   end
   assign mem_rdata = (wr_valid && mem_addr == wr_addr) ? wr_data :
                      (mem_addr == 16'h2005) ? 8'hA7 : (mem_addr[7:0] ^ mem_addr[15:8]);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Collect n acks in order (0=cpu, 1=col, 2=vrl). A requester whose drop bit
   // is set releases its req when it sees its ack.
   task automatic run_acks(input int n, input logic [2:0] drop, input int maxcyc);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < maxcyc) begin
         @(negedge clk);
         cyc++;
         if (cpu_ack) begin ack_log.push_back(0); got++; if (drop[0]) cpu_req = 1'b0; end
         if (col_ack) begin ack_log.push_back(1); got++; if (drop[1]) col_req = 1'b0; end
         if (vrl_ack) begin ack_log.push_back(2); got++; if (drop[2]) vrl_req = 1'b0; end
      end
      chk("acks_seen", 32'(got), 32'(n));
   endtask

   task automatic quiesce();
      cpu_req = 0; col_req = 0; vrl_req = 0; col_lock = 0; vrl_lock = 0; cpu_we = 0;
      repeat (4) @(negedge clk);
      ack_log.delete();
   endtask

   initial begin
      int cnt;
      int ack_cnt;
      rst = 1; render_active = 0;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      col_req = 0; col_lock = 0; col_addr = 16'h3F10;
      vrl_req = 0; vrl_lock = 0; vrl_addr = 16'h0120;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_acks", 32'({cpu_ack, col_ack, vrl_ack}), 0);
      rst = 0;
      @(negedge clk);

      // Single CPU read: the ack comes 2 cycles after the grant edge.
      cpu_addr = 16'h2005; cpu_we = 0; cpu_req = 1;
      @(negedge clk);
      chk("rd_addr", 32'(mem_addr), 32'h2005);
      chk("rd_busy", 32'(busy), 1);
      chk("rd_we", 32'(mem_we), 0);
      chk("rd_ack_e0", 32'(cpu_ack), 0);
      @(negedge clk);
      chk("rd_ack_e1", 32'(cpu_ack), 0);
      chk("rd_we_e1", 32'(mem_we), 0);
      @(negedge clk);
      chk("rd_ack", 32'(cpu_ack), 1);
      chk("rd_data", 32'(rdata), 32'hA7);
      cpu_req = 0;
      @(negedge clk);
      chk("rd_ack_pulse", 32'(cpu_ack), 0);
      chk("rd_idle", 32'(busy), 0);

      // CPU write: the strobe lasts exactly 1 cycle.
      cpu_addr = 16'h3F00; cpu_wdata = 8'h1D; cpu_we = 1; cpu_req = 1;
      @(negedge clk);
      chk("wr_we", 32'(mem_we), 1);
      chk("wr_addr", 32'(mem_addr), 32'h3F00);
      chk("wr_wdata", 32'(mem_wdata), 32'h1D);
      @(negedge clk);
      chk("wr_we_clr", 32'(mem_we), 0);
      chk("wr_ack_e1", 32'(cpu_ack), 0);
      @(negedge clk);
      chk("wr_ack", 32'(cpu_ack), 1);
      cpu_req = 0; cpu_we = 0;
      @(negedge clk);
      chk("wr_ack_pulse", 32'(cpu_ack), 0);

      // Read back the written location.
      cpu_req = 1;
      run_acks(1, 3'b001, 20);
      chk("rb_data", 32'(rdata), 32'h1D);
      quiesce();

      // Fixed priority while rendering: vrl, col, cpu.
      render_active = 1;
      cpu_req = 1; col_req = 1; vrl_req = 1;
      run_acks(3, 3'b111, 40);
      chk("prio_render", 32'(ack_log[0]*100 + ack_log[1]*10 + ack_log[2]), 210);
      quiesce();

      // Fixed priority outside rendering: cpu, col, vrl.
      render_active = 0;
      cpu_req = 1; col_req = 1; vrl_req = 1;
      run_acks(3, 3'b111, 40);
      chk("prio_idle", 32'(ack_log[0]*100 + ack_log[1]*10 + ack_log[2]), 12);
      quiesce();

      // Starvation guard: 16 vrl grants, then the CPU on the 17th arbitration.
      // A second round shows that cpu_wait restarted from zero.
      render_active = 1;
      vrl_req = 1;
      for (int r = 0; r < 2; r++) begin
         ack_log.delete();
         cpu_req = 1;
         run_acks(17, 3'b001, 100);
         cnt = 0;
         for (int i = 0; i < 16 && i < ack_log.size(); i++) if (ack_log[i] == 2) cnt++;
         chk("starve_vrl_cnt", 32'(cnt), 16);
         chk("starve_cpu_17th", 32'(ack_log.size() > 16 ? ack_log[16] : -1), 0);
      end
      quiesce();

      // Lock: col keeps the bus for 32 reads while vrl is pending.
      render_active = 1;
      col_req = 1; col_lock = 1;
      run_acks(1, 3'b000, 20);
      vrl_req = 1;
      for (int i = 0; i < 31; i++) run_acks(1, 3'b000, 20);
      col_lock = 0;
      run_acks(1, 3'b111, 20);
      cnt = 0;
      for (int i = 0; i < 32 && i < ack_log.size(); i++) if (ack_log[i] == 1) cnt++;
      chk("lock_col_cnt", 32'(cnt), 32);
      chk("lock_then_vrl", 32'(ack_log.size() > 32 ? ack_log[32] : -1), 2);
      quiesce();

      // Reset in the middle of an access.
      render_active = 0;
      cpu_addr = 16'h2005; cpu_wdata = 8'h1D; cpu_req = 1;
      @(negedge clk);
      chk("mid_busy", 32'(busy), 1);
      rst = 1;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_addr", 32'(mem_addr), 0);
      chk("mid_rst_wdata", 32'(mem_wdata), 0);
      chk("mid_rst_rdata", 32'(rdata), 0);
      chk("mid_rst_we_ack", 32'({mem_we, cpu_ack, col_ack, vrl_ack}), 0);
      @(negedge clk);
      rst = 0; cpu_req = 0;
      ack_cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (cpu_ack || col_ack || vrl_ack) ack_cnt++;
      end
      chk("mid_rst_no_ack", 32'(ack_cnt), 0);
      ack_log.delete();
      cpu_addr = 16'h2005; cpu_req = 1;
      run_acks(1, 3'b001, 20);
      chk("post_rst_data", 32'(rdata), 32'hA7);
      chk("post_rst_who", 32'(ack_log.size() > 0 ? ack_log[0] : -1), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ppu_vram_arbiter.md
Name: ppu_vram_arbiter

Overview:
- Single owner of the PPU VRAM bus.
- Shares the bus between three requesters:
  - CPU PPUDATA port (read/write)
  - palette/colour loader (read only)
  - background/sprite tile fetcher (read only)
- Replaces ad-hoc sharing of the vram address bus. Sits between the PPU sequencing FSMs and the VRAM/palette memory.
- Priority depends on whether the frame is being rendered. The CPU has a starvation guard, and burst requesters get a lock.

Parameters:
RD_LAT, 1, memory read latency in cycles from mem_addr valid to mem_rdata valid (1..4)
MAX_WAIT, 16, consecutive arbitration losses after which the CPU is force-granted (2..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
render_active  in  1  1 = frame render in progress
cpu_req  in  1  CPU access request
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  16  CPU VRAM address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse
col_req  in  1  colour loader request
col_lock  in  1  keep grant for next access
col_addr  in  16  colour loader address
col_ack  out  1  completion pulse
vrl_req  in  1  tile fetcher request
vrl_lock  in  1  keep grant for next access
vrl_addr  in  16  tile fetcher address
vrl_ack  out  1  completion pulse
rdata  out  8  read data, valid while any ack is high
mem_addr  out  16  VRAM address
mem_we  out  1  VRAM write strobe
mem_wdata  out  8  VRAM write data
mem_rdata  in  8  VRAM read data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous on rst=1:
  - state=IDLE; all acks, mem_we and busy = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - owner = none; cpu_wait = 0.
  - An access in progress when reset hits is abandoned and never acked.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Pick a winner among asserted reqs.
  - Register owner, mem_addr <= winner addr, mem_wdata <= cpu_wdata, mem_we <= (winner==cpu && cpu_we).
  - Load cnt <= RD_LAT, then go to ACCESS.
  - No req asserted: stay in IDLE, outputs held.
- ACCESS:
  - mem_we is cleared after the first ACCESS cycle, so a write strobe is exactly 1 cycle.
  - cnt decrements; when cnt==0, rdata <= mem_rdata, pulse the owner's ack, go to DONE.
- DONE: ack high for exactly one cycle, then IDLE.
- Latency and throughput:
  - Ack rises RD_LAT+1 cycles after the IDLE grant edge.
  - One access per RD_LAT+3 cycles.
- Requester rules:
  - Hold req, addr, we and wdata stable from assertion until its ack.
  - Drop req, or present the next address, at the ack edge.
- Write access: ack is still given; rdata takes whatever mem_rdata holds and is don't-care to the requester.
- Priority, evaluated in IDLE, highest rule first:
  1. cpu_req with cpu_wait==MAX_WAIT.
  2. Previous owner's lock && req. The previous owner is col or vrl only; CPU has no lock.
  3. render_active=1: vrl > col > cpu.
  4. render_active=0: cpu > col > vrl.
- cpu_wait:
  - Increments, saturating at MAX_WAIT, on every IDLE arbitration where cpu_req=1 and CPU loses.
  - Clears when CPU is granted.
- render_active is sampled only in IDLE; toggling it mid-access does not affect the current access.
- Simultaneous requests with none of the higher rules applying: fixed priority only, no round robin.
- Widths: addresses pass through unmodified. Mirroring is not this block's job.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- Defined:
  - Adds output cpu_stall_cnt [15:0].
  - Increments every cycle cpu_req=1 and cpu_ack=0.
  - Saturates at 16'hFFFF; cleared by rst only.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Single CPU read, RD_LAT=1, cpu_addr=16'h2005, mem model returns 8'hA7 → mem_addr=16'h2005 one cycle after grant; cpu_ack pulses exactly once 2 cycles after grant with rdata=8'hA7; mem_we stays 0.
- CPU write 16'h3F00 / 8'h1D → mem_we high exactly 1 cycle with mem_addr=16'h3F00 and mem_wdata=8'h1D; cpu_ack follows one pulse later.
- render_active=1, vrl_req, col_req and cpu_req asserted together → grant order vrl, col, cpu; render_active=0 with the same stimulus → order cpu, col, vrl.
- render_active=1, vrl_req held continuously, cpu_req held → CPU granted on the 17th arbitration with MAX_WAIT=16; cpu_wait returns to 0.
- col_lock=1 over 32 reads with vrl_req also pending → 32 consecutive col_acks with no vrl grant in between; vrl is granted the arbitration after col_lock drops.
- rst pulsed mid-ACCESS → all outputs 0 immediately; no ack for the abandoned access; a new request after rst deasserts completes normally.
